// File: rtl/booth_pkg.sv
// Shared FSM state codes and Booth recoding helpers for the sequential Booth multiplier.
package booth_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] BOOTH_NOP = 2'd0;
  localparam logic [1:0] BOOTH_ADD = 2'd1;
  localparam logic [1:0] BOOTH_SUB = 2'd2;

  // Radix-2 recoding of the current multiplier bit pair {Q[0], Q_1}.
  function automatic logic [1:0] booth_sel(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M, then an
// arithmetic right shift of {acc, q, q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N-1:0] m,
  output logic [N:0]   acc_next,
  output logic [N-1:0] q_next,
  output logic         q_1_next
);

  logic [N:0] m_ext;
  logic [N:0] sum;

  // The extra acc bit keeps acc - m exact when m is the most-negative value.
  always_comb begin
    m_ext = {m[N-1], m};
    sum   = acc;
    case (booth_sel(q[0], q_1))
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
    acc_next = {sum[N], sum[N:1]};
    q_next   = {sum[0], q[N-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, with a start/busy/done handshake.
// Operands are extended by one bit so the signed datapath also covers unsigned inputs.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [N-1:0]  m;
  logic [N-1:0]  q;
  logic [N:0]    acc;
  logic          q_1;
  logic [CW-1:0] cnt;

  logic [N:0]    acc_step;
  logic [N-1:0]  q_step;
  logic          q_1_step;
  logic [N-1:0]  a_ext;
  logic [N-1:0]  b_ext;
  logic          accept;
  logic          last_step;

  assign a_ext     = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext     = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (state == RUN) && (cnt == LAST);

  booth_step #(.N(N)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step),
    .q_1_next (q_1_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = last_step ? DONE : RUN;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // The product register is only written on the step that enters DONE, so it
  // holds the previous result throughout a following operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      m   <= a_ext;
      q   <= b_ext;
      acc <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_step;
      q   <= q_step;
      q_1 <= q_1_step;
      cnt <= cnt + CW'(1);
      if (last_step) product <= {acc_step[WIDTH-2:0], q_step};
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq: directed corner cases plus a
// randomized sweep against an integer-arithmetic reference model (WIDTH=8 and 4).
module tb_booth_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  booth_multiplier_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
  );

  // Product as plain integers, truncated to 2*w bits.
  function automatic longint ref_model(int w, bit sm, longint x, longint y);
    longint sx = x;
    longint sy = y;
    if (sm && x[w-1]) sx = x - (longint'(1) << w);
    if (sm && y[w-1]) sy = y - (longint'(1) << w);
    return (sx * sy) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Launch one operation, scramble inputs afterwards, wait (bounded) for done.
  task automatic run8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int lat, output int busy_n);
    @(negedge clk);
    sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    lat = 1; busy_n = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_n++;
      @(negedge clk);
      lat++;
    end
    p = product8;
  endtask

  task automatic run4(input logic sm, input logic [3:0] x, input logic [3:0] y,
                      output logic [7:0] p, output int lat);
    @(negedge clk);
    sm4 = sm; a4 = x; b4 = y; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = product4;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy8, done8, product8} !== 18'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset8: busy=%b done=%b product=%h, want 0/0/0000", busy8, done8, product8);
    end
    tests_run++;
    if ({busy4, done4, product4} !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset4: busy=%b done=%b product=%h, want 0/0/00", busy4, done4, product4);
    end
    rst = 1'b0;
  endtask

  task automatic test_signed_basic;
    logic [15:0] p; int lat, bn;
    run8(1'b1, 8'd7, 8'hFD, p, lat, bn);
    tests_run++;
    if (lat !== 10) begin
      tests_failed++;
      $display("[TB] FAIL latency_7x-3: got cycle k+%0d, want k+10", lat);
    end
    tests_run++;
    if (bn !== 9) begin
      tests_failed++;
      $display("[TB] FAIL busy_cycles: got %0d, want 9", bn);
    end
    tests_run++;
    if (p !== 16'hFFEB) begin
      tests_failed++;
      $display("[TB] FAIL product_7x-3: got %h, want ffeb", p);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] p; int lat, bn;
    logic [15:0] want [6] = '{16'h4000, 16'hC080, 16'hFE01, 16'h0100, 16'h0000, 16'h0000};
    logic [7:0]  xa   [6] = '{8'h80, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h00};
    logic [7:0]  xb   [6] = '{8'h80, 8'h7F, 8'hFF, 8'h02, 8'h00, 8'h55};
    logic        xs   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run8(xs[i], xa[i], xb[i], p, lat, bn);
      tests_run++;
      if (p !== want[i] || lat !== 10) begin
        tests_failed++;
        $display("[TB] FAIL boundary%0d: product=%h lat=%0d, want %h lat=10", i, p, lat, want[i]);
      end
    end
  endtask

  task automatic test_start_during_run;
    int done_n = 0, at = 0;
    logic [15:0] got = '0;
    @(negedge clk);
    sm8 = 1'b1; a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (done8) begin done_n++; at = cyc; got = product8; end
      start8 = (cyc == 3 || cyc == 5);
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    tests_run++;
    if (done_n !== 1 || at !== 10) begin
      tests_failed++;
      $display("[TB] FAIL start_in_run_done: count=%0d at=%0d, want 1 at 10", done_n, at);
    end
    tests_run++;
    if (got !== 16'd30) begin
      tests_failed++;
      $display("[TB] FAIL start_in_run_product: got %h, want 001e", got);
    end
  endtask

  task automatic test_reset_during_run;
    logic [15:0] p; int lat, bn, done_n;
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy8, done8, product8} !== 18'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort: busy=%b done=%b product=%h, want 0/0/0000", busy8, done8, product8);
    end
    rst = 1'b0;
    done_n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) done_n++;
    end
    tests_run++;
    if (done_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: got %0d pulses, want 0", done_n);
    end
    run8(1'b1, 8'hFE, 8'd3, p, lat, bn);
    tests_run++;
    if (p !== 16'hFFFA || lat !== 10) begin
      tests_failed++;
      $display("[TB] FAIL after_abort: product=%h lat=%0d, want fffa lat=10", p, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p1; int lat, bn;
    logic stable;
    run8(1'b1, 8'd100, 8'hCE, p1, lat, bn);
    tests_run++;
    if (p1 !== 16'(ref_model(8, 1'b1, 100, 8'hCE))) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h, want %h", p1, 16'(ref_model(8, 1'b1, 100, 8'hCE)));
    end
    sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1; stable = 1'b1;
    while (!done8 && lat < 40) begin
      if (product8 !== p1) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_hold: product changed during run, got %b want 1", stable);
    end
    tests_run++;
    if (lat !== 10 || product8 !== 16'h0258) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: product=%h lat=%0d, want 0258 lat=10", product8, lat);
    end
  endtask

  task automatic test_width4;
    logic [7:0] p; int lat;
    run4(1'b1, 4'h8, 4'h7, p, lat);
    tests_run++;
    if (p !== 8'hC8 || lat !== 6) begin
      tests_failed++;
      $display("[TB] FAIL w4_-8x7: product=%h lat=%0d, want c8 lat=6", p, lat);
    end
    for (int i = 0; i < 20; i++) begin
      logic       s = 1'($urandom);
      logic [3:0] x = 4'($urandom);
      logic [3:0] y = 4'($urandom);
      run4(s, x, y, p, lat);
      tests_run++;
      if (p !== 8'(ref_model(4, s, x, y)) || lat !== 6) begin
        tests_failed++;
        $display("[TB] FAIL w4_rand: s=%b %h*%h product=%h lat=%0d, want %h lat=6",
                 s, x, y, p, lat, 8'(ref_model(4, s, x, y)));
      end
    end
  endtask

  task automatic test_random_sweep;
    logic [15:0] p; int lat, bn;
    for (int i = 0; i < 40; i++) begin
      logic       s = 1'($urandom);
      logic [7:0] x = 8'($urandom);
      logic [7:0] y = 8'($urandom);
      run8(s, x, y, p, lat, bn);
      tests_run++;
      if (p !== 16'(ref_model(8, s, x, y)) || lat !== 10) begin
        tests_failed++;
        $display("[TB] FAIL w8_rand: s=%b %h*%h product=%h lat=%0d, want %h lat=10",
                 s, x, y, p, lat, 16'(ref_model(8, s, x, y)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_boundaries();
    test_start_during_run();
    test_reset_during_run();
    test_back_to_back();
    test_width4();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
